// File: rtl/superio_irqhub.sv
`default_nettype none
// ============================================================================
//  Module      : superio_irqhub
//  Description : Interrupt and software-reset concentrator for the SuperIO
//                CPU bus. Up to 16 asynchronous sources are synchronised,
//                latched per source as level or rising-edge, masked, routed
//                to one of two active-low CPU IRQ lines, and presented as a
//                per-line priority vector. A keyed register write launches a
//                timed active-low software reset pulse.
//
//  Ports       : clk      - bus clock (E)
//                rst_n    - asynchronous active-low reset
//                AD       - register address (16-byte window)
//                DI       - write data
//                DO       - read data, combinational from AD, 0x00 when cs=0
//                rw       - 1 = read, 0 = write
//                cs       - block select, write on rising clk with cs=1, rw=0
//                src      - raw interrupt sources, asynchronous, active-high
//                irq_n    - CPU IRQ lines [1:0], active-low, registered
//                sw_rst_n - software reset request, active-low, registered
//
//  Register map: 0/1 STATUS  2/3 PEND (W1C, edge mode)  4/5 MASK
//                6/7 MODE    8/9 ROUTE  A VEC0  B VEC1  C SWRST
//
//  Revision    : 1.0 - initial release
// ============================================================================
module superio_irqhub #(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RST_LEN     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      AD,
    input  logic [7:0]      DI,
    output logic [7:0]      DO,
    input  logic            rw,
    input  logic            cs,
    input  logic [NSRC-1:0] src,
    output logic [1:0]      irq_n,
    output logic            sw_rst_n
);

    // Internal datapath is always 16 wide; bits at index >= NSRC are forced
    // to zero so they read 0, ignore writes and can never become active.
    localparam logic [15:0] c_valid     = 16'((32'd1 << NSRC) - 32'd1);
    localparam logic [7:0]  c_rst_len   = 8'(RST_LEN);
    localparam logic [7:0]  c_swrst_key = 8'hA5;

    logic [15:0] w_src_ext;
    logic [15:0] r_sync_pipe [SYNC_STAGES];
    logic [15:0] w_sync;
    logic [15:0] r_prev;
    logic [15:0] r_pend;
    logic [15:0] r_mask;
    logic [15:0] r_mode;
    logic [15:0] r_route;
    logic [15:0] w_clr;
    logic [15:0] w_pend_nxt;
    logic [15:0] w_act;
    logic [15:0] w_act0;
    logic [15:0] w_act1;
    logic [7:0]  w_vec0;
    logic [7:0]  w_vec1;
    logic [1:0]  r_irq_n;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_sw_rst_n;
    logic        w_wr;
    logic        w_swrst_wr;

    assign w_src_ext = 16'(src);
    assign w_wr      = cs & ~rw;

    // ------------------------------------------------------------------
    // Source synchronisers plus one history stage for edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync_pipe[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync_pipe[0] <= w_src_ext;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync_pipe[s] <= r_sync_pipe[s-1];
            end
            r_prev <= w_sync;
        end
    end

    assign w_sync = r_sync_pipe[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_mode  <= '0;
            r_route <= '0;
        end else if (w_wr) begin
            case (AD)
                4'h4:    r_mask[7:0]   <= DI & c_valid[7:0];
                4'h5:    r_mask[15:8]  <= DI & c_valid[15:8];
                4'h6:    r_mode[7:0]   <= DI & c_valid[7:0];
                4'h7:    r_mode[15:8]  <= DI & c_valid[15:8];
                4'h8:    r_route[7:0]  <= DI & c_valid[7:0];
                4'h9:    r_route[15:8] <= DI & c_valid[15:8];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending latch. Level bits track sync; edge bits set on a rising
    // sync and clear by W1C, with a same-cycle set taking precedence.
    // ------------------------------------------------------------------
    always_comb begin
        w_clr = '0;
        if (w_wr && AD == 4'h2) w_clr[7:0]  = DI;
        if (w_wr && AD == 4'h3) w_clr[15:8] = DI;
    end

    assign w_pend_nxt = ((~r_mode & w_sync) |
                         (r_mode & ((w_sync & ~r_prev) | (r_pend & ~w_clr)))) & c_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Line routing, IRQ outputs and priority vectors
    // ------------------------------------------------------------------
    assign w_act  = r_pend & r_mask;
    assign w_act0 = w_act & ~r_route;
    assign w_act1 = w_act & r_route;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_n <= 2'b11;
        end else begin
            r_irq_n <= {~(|w_act1), ~(|w_act0)};
        end
    end

    assign irq_n = r_irq_n;

    // Scan from the top down so the lowest active index is the last write.
    always_comb begin
        w_vec0 = 8'h00;
        w_vec1 = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            if (w_act0[i]) w_vec0 = {1'b1, 3'b000, 4'(i)};
            if (w_act1[i]) w_vec1 = {1'b1, 3'b000, 4'(i)};
        end
    end

    // ------------------------------------------------------------------
    // Software reset pulse. The output flop is loaded from the next counter
    // value so sw_rst_n goes low on the write edge and stays low for exactly
    // RST_LEN cycles; a keyed write while busy reloads the counter.
    // ------------------------------------------------------------------
    assign w_swrst_wr = w_wr && (AD == 4'hC) && (DI == c_swrst_key);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_swrst_wr) begin
            w_cnt_nxt = c_rst_len;
        end else if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 8'd0;
            r_sw_rst_n <= 1'b1;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_sw_rst_n <= (w_cnt_nxt == 8'd0);
        end
    end

    assign sw_rst_n = r_sw_rst_n;

    // ------------------------------------------------------------------
    // Read mux, free of side effects
    // ------------------------------------------------------------------
    always_comb begin
        DO = 8'h00;
        if (cs) begin
            case (AD)
                4'h0:    DO = w_sync[7:0];
                4'h1:    DO = w_sync[15:8];
                4'h2:    DO = r_pend[7:0];
                4'h3:    DO = r_pend[15:8];
                4'h4:    DO = r_mask[7:0];
                4'h5:    DO = r_mask[15:8];
                4'h6:    DO = r_mode[7:0];
                4'h7:    DO = r_mode[15:8];
                4'h8:    DO = r_route[7:0];
                4'h9:    DO = r_route[15:8];
                4'hA:    DO = w_vec0;
                4'hB:    DO = w_vec1;
                4'hC:    DO = {(r_cnt != 8'd0), 7'b0000000};
                default: DO = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_superio_irqhub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_superio_irqhub
//  Description : Self-checking bench for superio_irqhub. A 16-source instance
//                is tracked cycle by cycle against a behavioural model built
//                from a sample-history queue; a 5-source instance covers the
//                register width boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_superio_irqhub;

    localparam int SS = 2;
    localparam int RL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  AD = '0;
    logic [7:0]  DI = '0;
    logic        rw = 1'b1;
    logic        cs = 1'b0;
    logic        cs_s = 1'b0;
    logic [15:0] src = '0;
    logic [7:0]  DO;
    logic [7:0]  DO_s;
    logic [1:0]  irq_n;
    logic [1:0]  irq_n_s;
    logic        sw_rst_n;
    logic        sw_rst_n_s;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    superio_irqhub #(.NSRC(16), .SYNC_STAGES(SS), .RST_LEN(RL)) u_dut (
        .clk(clk), .rst_n(rst_n), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .src(src), .irq_n(irq_n), .sw_rst_n(sw_rst_n)
    );

    superio_irqhub #(.NSRC(5), .SYNC_STAGES(3), .RST_LEN(3)) u_small (
        .clk(clk), .rst_n(rst_n), .AD(AD), .DI(DI), .DO(DO_s), .rw(rw), .cs(cs_s),
        .src(src[4:0]), .irq_n(irq_n_s), .sw_rst_n(sw_rst_n_s)
    );

    // ---------------- behavioural model of the 16-source instance ----------
    // m_hist[0] is the newest clock sample of src; the synchronised level is
    // the sample SS edges old and the edge-detect history one older.
    logic [15:0] m_hist[$];
    logic [15:0] m_pend, m_mask, m_mode, m_route;
    logic [1:0]  m_irq_n;
    logic        m_sw;
    int          m_cnt;

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i <= SS; i++) m_hist.push_back(16'h0000);
        m_pend = '0; m_mask = '0; m_mode = '0; m_route = '0;
        m_irq_n = 2'b11; m_sw = 1'b1; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [15:0] sy, pv, act, clr, np;
        logic        load;
        sy  = m_hist[SS-1];
        pv  = m_hist[SS];
        act = m_pend & m_mask;
        clr = '0;
        load = 1'b0;
        if (cs && !rw && AD == 4'h2) clr[7:0]  = DI;
        if (cs && !rw && AD == 4'h3) clr[15:8] = DI;
        for (int i = 0; i < 16; i++) begin
            if (!m_mode[i])             np[i] = sy[i];
            else if (sy[i] && !pv[i])   np[i] = 1'b1;
            else if (clr[i])            np[i] = 1'b0;
            else                        np[i] = m_pend[i];
        end
        m_irq_n[0] = ((act & ~m_route) == 16'h0);
        m_irq_n[1] = ((act & m_route) == 16'h0);
        if (cs && !rw) begin
            case (AD)
                4'h4: m_mask[7:0]   = DI;
                4'h5: m_mask[15:8]  = DI;
                4'h6: m_mode[7:0]   = DI;
                4'h7: m_mode[15:8]  = DI;
                4'h8: m_route[7:0]  = DI;
                4'h9: m_route[15:8] = DI;
                4'hC: load = (DI == 8'hA5);
                default: ;
            endcase
        end
        if (load) m_cnt = RL;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        m_sw = (m_cnt == 0);
        m_hist.push_front(src);
        void'(m_hist.pop_back());
        m_pend = np;
    endtask

    function automatic logic [7:0] m_vec(input logic line);
        logic [15:0] act;
        act = m_pend & m_mask;
        for (int i = 0; i < 16; i++)
            if (act[i] && m_route[i] == line) return 8'h80 | 8'(i);
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        logic [15:0] sy;
        sy = m_hist[SS-1];
        case (a)
            4'h0: return sy[7:0];
            4'h1: return sy[15:8];
            4'h2: return m_pend[7:0];
            4'h3: return m_pend[15:8];
            4'h4: return m_mask[7:0];
            4'h5: return m_mask[15:8];
            4'h6: return m_mode[7:0];
            4'h7: return m_mode[15:8];
            4'h8: return m_route[7:0];
            4'h9: return m_route[15:8];
            4'hA: return m_vec(1'b0);
            4'hB: return m_vec(1'b1);
            4'hC: return (m_cnt != 0) ? 8'h80 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- check and drive helpers ------------------------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("irq_n_model", {6'b0, irq_n}, {6'b0, m_irq_n});
        chk("sw_rst_n_model", {7'b0, sw_rst_n}, {7'b0, m_sw});
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        tick();
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic wr_s(input logic [3:0] a, input logic [7:0] d);
        AD = a; DI = d; rw = 1'b0; cs_s = 1'b1;
        tick();
        cs_s = 1'b0; rw = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a);
        AD = a; rw = 1'b1; cs = 1'b1;
        #1;
        chk(tag, DO, m_read(a));
        cs = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [3:0] a, input logic [7:0] exp);
        AD = a; rw = 1'b1; cs = 1'b1;
        #1;
        chk(tag, DO, exp);
        cs = 1'b0;
    endtask

    task automatic rd_exp_s(input string tag, input logic [3:0] a, input logic [7:0] exp);
        AD = a; rw = 1'b1; cs_s = 1'b1;
        #1;
        chk(tag, DO_s, exp);
        cs_s = 1'b0;
    endtask

    // Hold reset with wandering sources, then check every visible value.
    task automatic reset_hold_and_check();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 src = 16'($urandom);
        end
        chk("rst_irq_n", {6'b0, irq_n}, 8'h03);
        chk("rst_sw_rst_n", {7'b0, sw_rst_n}, 8'h01);
        for (int a = 0; a < 16; a++) begin
            AD = 4'(a); rw = 1'b1; cs = 1'b1;
            #1;
            chk($sformatf("rst_reg_%0h", a), DO, 8'h00);
        end
        cs = 1'b0;
        src = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    int lowcnt;

    initial begin
        model_reset();

        // ---- reset state ----
        reset_hold_and_check();
        for (int k = 0; k < 3; k++) tick();

        // ---- level path on source 3 ----
        wr(4'h4, 8'h08);
        src[3] = 1'b1;
        tick(); tick();
        rd_exp("lvl_status", 4'h0, 8'h08);
        tick();
        rd_exp("lvl_vec0", 4'hA, 8'h83);
        tick();
        chk("lvl_irq_low", {6'b0, irq_n}, 8'h02);
        src[3] = 1'b0;
        tick(); tick(); tick();
        chk("lvl_irq_hold", {6'b0, irq_n}, 8'h02);
        tick();
        chk("lvl_irq_release", {6'b0, irq_n}, 8'h03);

        // ---- edge latch and W1C on source 0 ----
        wr(4'h6, 8'h01);
        wr(4'h4, 8'h01);
        src[0] = 1'b1;
        tick(); tick(); tick();
        src[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rd_exp("edge_pend_latched", 4'h2, 8'h01);
        chk("edge_irq_low", {6'b0, irq_n}, 8'h02);
        wr(4'h2, 8'h01);
        rd_exp("edge_pend_cleared", 4'h2, 8'h00);
        tick();
        chk("edge_irq_released", {6'b0, irq_n}, 8'h03);
        src[0] = 1'b1;
        tick(); tick();
        wr(4'h2, 8'h01);
        rd_exp("edge_set_wins", 4'h2, 8'h01);
        src[0] = 1'b0;
        tick(); tick(); tick();
        wr(4'h2, 8'h01);
        tick();
        rd_exp("edge_pend_final", 4'h2, 8'h00);

        // ---- priority and routing ----
        wr(4'h6, 8'h00);
        wr(4'h4, 8'hFF);
        wr(4'h5, 8'hFF);
        wr(4'h9, 8'h80);
        src = 16'h8220;
        for (int k = 0; k < 4; k++) tick();
        rd_exp("prio_vec0", 4'hA, 8'h85);
        rd_exp("prio_vec1", 4'hB, 8'h8F);
        chk("prio_irq_both", {6'b0, irq_n}, 8'h00);
        wr(4'h4, 8'hDF);
        rd_exp("prio_vec0_masked", 4'hA, 8'h89);
        src = '0;
        wr(4'h4, 8'h00);
        wr(4'h5, 8'h00);
        wr(4'h9, 8'h00);
        for (int k = 0; k < 4; k++) tick();

        // ---- software reset pulse ----
        wr(4'hC, 8'h55);
        chk("swrst_bad_key", {7'b0, sw_rst_n}, 8'h01);
        rd_exp("swrst_idle", 4'hC, 8'h00);
        wr(4'hC, 8'hA5);
        rd_exp("swrst_busy", 4'hC, 8'h80);
        AD = 4'hC; cs = 1'b0; #1;
        chk("do_deselected", DO, 8'h00);
        lowcnt = (sw_rst_n == 1'b0) ? 1 : 0;
        for (int k = 0; k < 100 && sw_rst_n == 1'b0; k++) begin
            tick();
            if (sw_rst_n == 1'b0) lowcnt++;
        end
        chk("swrst_len", 8'(lowcnt), 8'd16);

        wr(4'hC, 8'hA5);
        lowcnt = (sw_rst_n == 1'b0) ? 1 : 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (sw_rst_n == 1'b0) lowcnt++;
        end
        wr(4'hC, 8'hA5);
        if (sw_rst_n == 1'b0) lowcnt++;
        for (int k = 0; k < 100 && sw_rst_n == 1'b0; k++) begin
            tick();
            if (sw_rst_n == 1'b0) lowcnt++;
        end
        chk("swrst_retrigger_len", 8'(lowcnt), 8'd26);

        wr(4'hC, 8'hA5);
        for (int k = 0; k < 4; k++) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("swrst_async_abort", {7'b0, sw_rst_n}, 8'h01);
        reset_hold_and_check();
        for (int k = 0; k < 3; k++) tick();

        // ---- width boundary on the 5-source instance ----
        wr_s(4'h4, 8'hFF);
        wr_s(4'h5, 8'hFF);
        rd_exp_s("w5_mask_lo", 4'h4, 8'h1F);
        rd_exp_s("w5_mask_hi", 4'h5, 8'h00);
        src[2] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("w5_irq_low", {6'b0, irq_n_s}, 8'h02);
        wr_s(4'h2, 8'hFF);
        wr_s(4'h3, 8'hFF);
        tick();
        chk("w5_pend_write_no_effect", {6'b0, irq_n_s}, 8'h02);
        rd_exp_s("w5_pend", 4'h2, 8'h04);
        rd_exp_s("w5_status_hi", 4'h1, 8'h00);
        src = '0;
        for (int k = 0; k < 4; k++) tick();

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) src = src ^ (16'h0001 << $urandom_range(15));
            if ($urandom_range(2) == 0) begin
                AD = 4'($urandom_range(12));
                DI = 8'($urandom);
                if (AD == 4'hC && $urandom_range(1) == 1) DI = 8'hA5;
                rw = 1'b0; cs = 1'b1;
            end
            tick();
            cs = 1'b0; rw = 1'b1;
            rd_chk("rnd_reg", 4'($urandom_range(15)));
            rd_chk("rnd_vec0", 4'hA);
            rd_chk("rnd_vec1", 4'hB);
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
